// File: rtl/core_types_pkg.sv
// Purpose: shared core types for the writeback / complete-bus path.
//   phys_reg_tag_t       : physical register tag (64 physical registers)
//   word_t               : 32-bit result word
//   complete_bus_t       : one complete-bus beat {valid, tag, value}
//   complete_arb_entry_t : payload queued per writeback requester
package core_types_pkg;

    localparam int unsigned PHYS_REG_TAG_W       = 6;
    localparam int unsigned WORD_W               = 32;
    localparam int unsigned COMPLETE_ARB_NUM_REQ = 4;

    typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;
    typedef logic [WORD_W-1:0]         word_t;

    typedef struct packed {
        logic          valid;
        phys_reg_tag_t dest_phys_reg_tag;
        word_t         value;
    } complete_bus_t;

    typedef struct packed {
        phys_reg_tag_t dest_phys_reg_tag;
        word_t         value;
    } complete_arb_entry_t;

endpackage

// File: rtl/complete_arb_fifo.sv
// Purpose: small per-requester FIFO holding completed results awaiting a bus.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i/data_i  : push request and payload (ignored while full)
//   pop_i          : pop the head (ignored while empty)
//   full_o/empty_o : occupancy flags from registered count
//   head_o         : current head entry
//   count_err_o    : count exceeds depth (internal consistency flag)
module complete_arb_fifo
    import core_types_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  complete_arb_entry_t push_data_i,
    input  logic                pop_i,
    output logic                full_o,
    output logic                empty_o,
    output complete_arb_entry_t head_o,
    output logic                count_err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    complete_arb_entry_t mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    head_ptr_q, head_ptr_d;
    logic [PTR_W-1:0]    tail_ptr_q, tail_ptr_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic                do_push, do_pop;

    assign full_o      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_err_o = (count_q >  CNT_W'(FIFO_DEPTH));
    assign head_o      = mem_q[head_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // Pointer/count next state; depth is a power of two so pointers wrap naturally.
    always_comb begin
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        if (do_push) tail_ptr_d = tail_ptr_q + PTR_W'(1);
        if (do_pop)  head_ptr_d = head_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the count qualifies every entry.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/complete_bus_arbiter.sv
// Purpose: shares complete buses 0/1 among NUM_REQ writeback requesters.
//   Each requester pushes into its own FIFO; each cycle a round-robin scan
//   from rr_ptr grants up to two FIFO heads onto the registered buses.
// Ports:
//   CLK, RST                    : clock, synchronous active-high reset
//   DUT_error                   : registered one-cycle consistency error
//   req_valid/req_ready         : per-requester push handshake
//   req_dest_phys_reg_tag/value : per-requester payload
//   complete_bus_{0,1}_*        : registered bus outputs
// Optional: define COMPLETE_ARB_STARVE_CHECK_EN to add per-requester wait
//   counters that flag DUT_error when a head waits STARVE_LIMIT cycles.
module complete_bus_arbiter
    import core_types_pkg::*;
#(
    parameter int unsigned NUM_REQ      = COMPLETE_ARB_NUM_REQ,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    output logic                              DUT_error,
    input  logic          [NUM_REQ-1:0]       req_valid,
    output logic          [NUM_REQ-1:0]       req_ready,
    input  phys_reg_tag_t [NUM_REQ-1:0]       req_dest_phys_reg_tag,
    input  word_t         [NUM_REQ-1:0]       req_value,
    output logic                              complete_bus_0_valid,
    output phys_reg_tag_t                     complete_bus_0_dest_phys_reg_tag,
    output word_t                             complete_bus_0_value,
    output logic                              complete_bus_1_valid,
    output phys_reg_tag_t                     complete_bus_1_dest_phys_reg_tag,
    output word_t                             complete_bus_1_value
);

    localparam int unsigned RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]  fifo_full, fifo_empty, fifo_pop, fifo_cnt_err;
    complete_arb_entry_t fifo_head [NUM_REQ];

    logic [RR_W-1:0]     rr_q, rr_d;
    logic                gnt0_vld, gnt1_vld;
    logic [RR_W-1:0]     gnt0_idx, gnt1_idx;
    logic [RR_W:0]       scan_sum;

    complete_bus_t       bus0_q, bus0_d, bus1_q, bus1_d;
    logic                error_q, error_d;
    logic                dup_tag, starve_hit;

    assign req_ready = ~fifo_full;

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_fifo
        complete_arb_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i       (CLK),
            .rst_i       (RST),
            .push_i      (req_valid[i]),
            .push_data_i ('{dest_phys_reg_tag: req_dest_phys_reg_tag[i],
                            value:             req_value[i]}),
            .pop_i       (fifo_pop[i]),
            .full_o      (fifo_full[i]),
            .empty_o     (fifo_empty[i]),
            .head_o      (fifo_head[i]),
            .count_err_o (fifo_cnt_err[i])
        );
    end

    // Round-robin scan: first non-empty from rr_q goes to bus 0, next to bus 1.
    always_comb begin
        gnt0_vld = 1'b0;
        gnt1_vld = 1'b0;
        gnt0_idx = '0;
        gnt1_idx = '0;
        scan_sum = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (RR_W+1)'(k);
            if (scan_sum >= (RR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (RR_W+1)'(NUM_REQ);
            if (!fifo_empty[scan_sum[RR_W-1:0]]) begin
                if (!gnt0_vld) begin
                    gnt0_vld = 1'b1;
                    gnt0_idx = scan_sum[RR_W-1:0];
                end else if (!gnt1_vld) begin
                    gnt1_vld = 1'b1;
                    gnt1_idx = scan_sum[RR_W-1:0];
                end
            end
        end
    end

    // One pop per FIFO; the two winners are always distinct.
    always_comb begin
        fifo_pop = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            fifo_pop[i] = (gnt0_vld && (gnt0_idx == RR_W'(i)))
                       || (gnt1_vld && (gnt1_idx == RR_W'(i)));
        end
    end

    // Pointer moves just past the last winner so it goes to the back of the line.
    always_comb begin
        rr_d = rr_q;
        if (gnt1_vld) begin
            rr_d = (gnt1_idx == RR_W'(NUM_REQ-1)) ? '0 : gnt1_idx + RR_W'(1);
        end else if (gnt0_vld) begin
            rr_d = (gnt0_idx == RR_W'(NUM_REQ-1)) ? '0 : gnt0_idx + RR_W'(1);
        end
    end

    // Bus next state; payload holds when no grant.
    always_comb begin
        bus0_d       = bus0_q;
        bus1_d       = bus1_q;
        bus0_d.valid = gnt0_vld;
        bus1_d.valid = gnt1_vld;
        if (gnt0_vld) begin
            bus0_d.dest_phys_reg_tag = fifo_head[gnt0_idx].dest_phys_reg_tag;
            bus0_d.value             = fifo_head[gnt0_idx].value;
        end
        if (gnt1_vld) begin
            bus1_d.dest_phys_reg_tag = fifo_head[gnt1_idx].dest_phys_reg_tag;
            bus1_d.value             = fifo_head[gnt1_idx].value;
        end
    end

`ifdef COMPLETE_ARB_STARVE_CHECK_EN
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_q [NUM_REQ];
    logic [WAIT_W-1:0] wait_d [NUM_REQ];

    // Wait counters: clear on grant or empty, saturate at the limit; flag on arrival.
    always_comb begin
        starve_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (fifo_empty[i] || fifo_pop[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_W'(STARVE_LIMIT)) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
                if (wait_d[i] == WAIT_W'(STARVE_LIMIT)) starve_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (RST) wait_q[i] <= '0;
            else     wait_q[i] <= wait_d[i];
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Two buses carrying one nonzero tag would set the same ready bit twice.
    assign dup_tag = gnt0_vld && gnt1_vld
                  && (bus0_d.dest_phys_reg_tag == bus1_d.dest_phys_reg_tag)
                  && (bus0_d.dest_phys_reg_tag != '0);

    assign error_d = dup_tag || (|fifo_cnt_err) || starve_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_q    <= '0;
            bus0_q  <= '0;
            bus1_q  <= '0;
            error_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            bus0_q  <= bus0_d;
            bus1_q  <= bus1_d;
            error_q <= error_d;
        end
    end

    assign DUT_error                        = error_q;
    assign complete_bus_0_valid             = bus0_q.valid;
    assign complete_bus_0_dest_phys_reg_tag = bus0_q.dest_phys_reg_tag;
    assign complete_bus_0_value             = bus0_q.value;
    assign complete_bus_1_valid             = bus1_q.valid;
    assign complete_bus_1_dest_phys_reg_tag = bus1_q.dest_phys_reg_tag;
    assign complete_bus_1_value             = bus1_q.value;

endmodule

// File: doc/complete_bus_arbiter.md
Name: complete_bus_arbiter

Overview:
Shares the two complete buses that set entries in the physical register ready table among NUM_REQ functional-unit writeback requesters (ALU0, ALU1, MUL/DIV, load queue by default). Each requester pushes a completed result into its own small per-requester FIFO. Each cycle, a round-robin scheduler drains up to two FIFO heads onto complete bus 0 and complete bus 1. The bus outputs are registered and drive complete_bus_{0,1}_valid/dest_phys_reg_tag of the ready table, plus the PRF write ports.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)
FIFO_DEPTH, 2, entries per requester FIFO (power of 2, >=2)
STARVE_LIMIT, 8, max cycles a non-empty FIFO head may wait (optional feature only)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
DUT_error  out  1  registered internal-consistency error flag
req_valid  in  NUM_REQ  per-requester push request
req_ready  out  NUM_REQ  per-requester FIFO not full
req_dest_phys_reg_tag  in  NUM_REQ x phys_reg_tag_t  destination physical register
req_value  in  NUM_REQ x word_t  result data
complete_bus_0_valid  out  1  bus 0 carries a result
complete_bus_0_dest_phys_reg_tag  out  phys_reg_tag_t  bus 0 tag
complete_bus_0_value  out  word_t  bus 0 data
complete_bus_1_valid  out  1  bus 1 carries a result
complete_bus_1_dest_phys_reg_tag  out  phys_reg_tag_t  bus 1 tag
complete_bus_1_value  out  word_t  bus 1 data

Behaviour:
- One clock (CLK); reset (RST) is synchronous and active-high.
- Reset: all FIFOs empty, rr_ptr=0, bus valids=0, bus tags and values=0, DUT_error=0. Because all FIFOs are empty, req_ready is all 1s in the cycle after reset.
- Handshake: a push occurs at a posedge where req_valid[i] && req_ready[i]. req_ready[i] = !full[i], computed from registered state only. A full FIFO deasserts ready even if it pops in the same cycle. A valid without ready is held by the requester and is not an error.
- Latency: push at edge E0 -> entry at head after E0 -> granted and popped at E1 -> bus valid during the cycle after E1. Minimum latency is 2 edges. There is no bypass.
- Grant:
  - bus 0 gets the first non-empty FIFO scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - bus 1 gets the next non-empty FIFO after the bus 0 winner, in the same scan.
  - At most one pop per FIFO per cycle.
- rr_ptr update:
  - Two grants: rr_ptr <- (bus1 winner + 1) mod NUM_REQ.
  - One grant: rr_ptr <- (bus0 winner + 1) mod NUM_REQ.
  - No grant: rr_ptr unchanged.
- Bus registers: a bus valid with no grant loads 0. Its tag and value hold their previous contents (don't-care).
- FIFO: head/tail pointers wrap modulo FIFO_DEPTH, with a count of width clog2(FIFO_DEPTH)+1. A simultaneous push and pop on a non-full FIFO keeps count unchanged.
- DUT_error is set for one cycle (registered) in two cases:
  - Both grants in a cycle carry identical nonzero tags.
  - Any FIFO count exceeds FIFO_DEPTH.
- Reset mid-operation: all queued entries are discarded. Bus valids read 0 in the cycle after the reset edge.

Optional Feature:
Macro COMPLETE_ARB_STARVE_CHECK_EN.
- Defined: each requester has a wait counter that increments each cycle its FIFO is non-empty and not granted, and clears on grant or when empty. Reaching STARVE_LIMIT sets DUT_error (registered, one cycle) and saturates the counter.
- Undefined: no counters exist; DUT_error covers only the base conditions.

Decomposition:
- core_types_pkg supplies phys_reg_tag_t (6 bits, 64 phys regs) and word_t (32 bits).
- Add to core_types_pkg: complete_bus_t struct {valid, dest_phys_reg_tag, value} and COMPLETE_ARB_NUM_REQ = 4.
- One sub-module: complete_arb_fifo (parameterized FIFO_DEPTH, ports push/pop/full/empty/head), instantiated NUM_REQ times.

Test Plan:
- Reset: RST=1 for 2 cycles with req_valid=4'b1111 -> bus valids 0, req_ready 4'b1111 after release, no entries enqueued during reset, DUT_error 0.
- Single push: req 2 pushes tag 6'h15, value 32'hDEADBEEF at E0 -> bus 0 valid with 6'h15/32'hDEADBEEF in the cycle after E1, bus 1 invalid, rr_ptr=3.
- Round-robin fairness: all 4 requesters push once simultaneously (tags 1,2,3,4), rr_ptr=0 -> cycle A bus0=1, bus1=2; cycle B bus0=3, bus1=4; rr_ptr wraps to 0.
- Backpressure: req 0 pushes 3 times in consecutive cycles with other requesters busy -> req_ready[0]=0 after the 2nd push; the 3rd is held and accepted once a pop frees a slot; all 3 tags emerge in order.
- Duplicate tag: req 0 and req 1 each push tag 6'h0A in the same cycle -> both buses carry 6'h0A, DUT_error=1 for exactly one cycle.
- Reset mid-operation: FIFOs holding 5 entries, RST asserted 1 cycle -> bus valids 0 the cycle after; no stale entries appear after release.
